// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the Game Boy CPU core: control words, schedules, flags and
// the sequencer state encoding.
package gb_cpu_common_pkg;

    localparam int SCHED_DEPTH = 6;

    typedef enum logic [2:0] {
        R16_NONE, R16_PC, R16_SP, R16_BC, R16_DE, R16_HL, R16_WZ
    } r16_sel_t;

    typedef enum logic [1:0] {
        BUS_NONE, BUS_READ, BUS_WRITE
    } bus_op_t;

    typedef enum logic [3:0] {
        R8_NONE, R8_IR, R8_A, R8_F, R8_B, R8_C, R8_D, R8_E,
        R8_H, R8_L, R8_W, R8_Z, R8_SPH, R8_SPL, R8_PCH, R8_PCL
    } r8_sel_t;

    typedef enum logic [1:0] {
        IDU_NONE, IDU_INC, IDU_DEC
    } idu_op_t;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR,
        ALU_CP, ALU_INC, ALU_DEC, ALU_RLC, ALU_RRC, ALU_BIT, ALU_RES, ALU_SET
    } alu_op_t;

    typedef enum logic [1:0] {
        CC_NZ, CC_Z, CC_NC, CC_C
    } condition_code_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef struct packed {
        r16_sel_t addr_sel;
        bus_op_t  bus_op;
        r8_sel_t  recv_sel;
        idu_op_t  idu_op;
        r16_sel_t idu_src;
        r16_sel_t idu_dst;
        alu_op_t  alu_op;
        logic     cc_check;
    } control_signals_t;

    typedef struct packed {
        logic [2:0]                         m_cycles;
        condition_code_t                    condition;
        logic                               cb_prefix_next;
        logic                               bit_cmd;
        control_signals_t [SCHED_DEPTH-1:0] instruction_controls;
    } schedule_t;

    typedef enum logic [1:0] {
        SEQ_BOOT, SEQ_LOAD, SEQ_EXEC
    } seq_state_t;

    localparam control_signals_t CTRL_NOP = '0;

    // Opcode fetch: read [PC] into IR while the IDU post-increments PC.
    localparam control_signals_t FETCH_CTRL = '{
        addr_sel: R16_PC,
        bus_op:   BUS_READ,
        recv_sel: R8_IR,
        idu_op:   IDU_INC,
        idu_src:  R16_PC,
        idu_dst:  R16_PC,
        alu_op:   ALU_NOP,
        cc_check: 1'b0
    };

    function automatic logic cond_pass(input condition_code_t cc, input alu_flags_t f);
        case (cc)
            CC_NZ:   return !f.z;
            CC_Z:    return f.z;
            CC_NC:   return !f.c;
            default: return f.c;
        endcase
    endfunction

endpackage

// File: rtl/gb_cpu_sequencer.sv
// M-cycle sequencer: latches the decoded schedule (or the interrupt dispatch
// schedule) at each instruction boundary and steps its control words per tick.
module gb_cpu_sequencer
    import gb_cpu_common_pkg::*;
#(
    parameter int MAX_STEPS = SCHED_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mcycle_tick_i,
    input  schedule_t        sched_i,
    input  schedule_t        isr_sched_i,
    input  logic             irq_req_i,
    input  alu_flags_t       flags_i,
    output control_signals_t ctrl_o,
    output logic [2:0]       step_o,
    output logic             bit_cmd_o,
    output logic             cb_mode_o,
    output logic             instr_done_o,
    output logic             irq_ack_o
);

    seq_state_t       state;
    seq_state_t       state_next;
    schedule_t        latched;
    schedule_t        load_sched;
    control_signals_t ctrl_next;
    logic [2:0]       step;
    logic [2:0]       step_next;
    logic [2:0]       step_inc;
    logic [2:0]       last_step;
    logic             take_irq;
    logic             fail;
    logic             last;
    logic             unused_bits;

    assign unused_bits = ^{flags_i.n, flags_i.h, latched.cb_prefix_next};

    // Interrupts never split a CB prefix from its opcode; schedules shorter
    // than one step or longer than the table are clamped to fit.
    always_comb begin
        take_irq   = irq_req_i && !cb_mode_o;
        load_sched = take_irq ? isr_sched_i : sched_i;
        step_inc   = step + 3'd1;

        if (latched.m_cycles == 3'd0)
            last_step = 3'd0;
        else if (int'(latched.m_cycles) > MAX_STEPS)
            last_step = 3'(MAX_STEPS - 1);
        else
            last_step = latched.m_cycles - 3'd1;

        fail = ctrl_o.cc_check && !cond_pass(latched.condition, flags_i);
        last = (step == last_step) || fail;

        state_next = state;
        step_next  = step;
        ctrl_next  = ctrl_o;

        case (state)
            SEQ_BOOT: begin
                if (mcycle_tick_i) begin
                    state_next = SEQ_LOAD;
                    ctrl_next  = CTRL_NOP;
                end
            end
            SEQ_LOAD: begin
                state_next = SEQ_EXEC;
                step_next  = 3'd0;
                ctrl_next  = load_sched.instruction_controls[0];
            end
            SEQ_EXEC: begin
                if (mcycle_tick_i) begin
                    if (last) begin
                        state_next = SEQ_LOAD;
                        ctrl_next  = CTRL_NOP;
                    end else begin
                        step_next = step_inc;
                        ctrl_next = latched.instruction_controls[step_inc];
                    end
                end
            end
            default: begin
                state_next = SEQ_BOOT;
                ctrl_next  = FETCH_CTRL;
            end
        endcase
    end

    // The control word is registered so the datapath sees it stable for the
    // whole M-cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEQ_BOOT;
            step         <= 3'd0;
            latched      <= '0;
            ctrl_o       <= FETCH_CTRL;
            cb_mode_o    <= 1'b0;
            instr_done_o <= 1'b0;
            irq_ack_o    <= 1'b0;
        end else begin
            state        <= state_next;
            step         <= step_next;
            ctrl_o       <= ctrl_next;
            instr_done_o <= (state == SEQ_EXEC) && mcycle_tick_i && last;
            irq_ack_o    <= (state == SEQ_LOAD) && take_irq;
            if (state == SEQ_LOAD) begin
                latched <= load_sched;
                if (!take_irq)
                    cb_mode_o <= sched_i.cb_prefix_next;
            end
        end
    end

    assign step_o    = step;
    assign bit_cmd_o = latched.bit_cmd;

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Directed self-checking bench for gb_cpu_sequencer: boot, multi-cycle steps,
// conditional truncation, CB prefix interrupt masking, ISR dispatch, clamping, reset.
module tb_gb_cpu_sequencer;
    import gb_cpu_common_pkg::*;

    logic             clk;
    logic             reset;
    logic             mcycle_tick_i;
    schedule_t        sched_i;
    schedule_t        isr_sched_i;
    logic             irq_req_i;
    alu_flags_t       flags_i;
    control_signals_t ctrl_o;
    logic [2:0]       step_o;
    logic             bit_cmd_o;
    logic             cb_mode_o;
    logic             instr_done_o;
    logic             irq_ack_o;

    int checkCount = 0;
    int failCount  = 0;

    control_signals_t expFetch;
    schedule_t        schedA, schedJr, schedPre, schedCbOp, schedIsr;
    schedule_t        schedM0, schedM7, schedM5;

    gb_cpu_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .mcycle_tick_i (mcycle_tick_i),
        .sched_i       (sched_i),
        .isr_sched_i   (isr_sched_i),
        .irq_req_i     (irq_req_i),
        .flags_i       (flags_i),
        .ctrl_o        (ctrl_o),
        .step_o        (step_o),
        .bit_cmd_o     (bit_cmd_o),
        .cb_mode_o     (cb_mode_o),
        .instr_done_o  (instr_done_o),
        .irq_ack_o     (irq_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each id gives a distinct non-zero word: recv_sel from the upper nibble,
    // alu_op from the lower one.
    function automatic control_signals_t makeCtrl(input int id, input logic cc);
        control_signals_t c;
        logic [7:0] idb;
        idb        = id[7:0];
        c          = '0;
        c.recv_sel = r8_sel_t'(idb[7:4]);
        c.alu_op   = alu_op_t'(idb[3:0]);
        c.cc_check = cc;
        return c;
    endfunction

    function automatic schedule_t makeSched(input logic [2:0] m, input condition_code_t cond,
                                            input logic cbn, input logic bitc,
                                            input int k, input int ccStep);
        schedule_t s;
        s                = '0;
        s.m_cycles       = m;
        s.condition      = cond;
        s.cb_prefix_next = cbn;
        s.bit_cmd        = bitc;
        for (int i = 0; i < SCHED_DEPTH; i++)
            s.instruction_controls[i] = makeCtrl(16 * k + i, i == ccStep);
        return s;
    endfunction

    function automatic logic [31:0] cw(input control_signals_t c);
        return 32'(c);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; spans one clock and returns at the next falling edge.
    task automatic applyStimulus(input logic tick);
        mcycle_tick_i = tick;
        @(negedge clk);
        mcycle_tick_i = 1'b0;
    endtask

    initial begin
        expFetch          = '0;
        expFetch.addr_sel = R16_PC;
        expFetch.bus_op   = BUS_READ;
        expFetch.recv_sel = R8_IR;
        expFetch.idu_op   = IDU_INC;
        expFetch.idu_src  = R16_PC;
        expFetch.idu_dst  = R16_PC;

        schedA    = makeSched(3'd3, CC_NZ, 1'b0, 1'b1, 1, -1);
        schedJr   = makeSched(3'd3, CC_NZ, 1'b0, 1'b0, 2, 1);
        schedPre  = makeSched(3'd1, CC_NZ, 1'b1, 1'b0, 3, -1);
        schedCbOp = makeSched(3'd2, CC_NZ, 1'b0, 1'b1, 4, -1);
        schedIsr  = makeSched(3'd5, CC_NZ, 1'b0, 1'b0, 5, -1);
        schedM0   = makeSched(3'd0, CC_NZ, 1'b0, 1'b0, 6, -1);
        schedM7   = makeSched(3'd7, CC_NZ, 1'b0, 1'b0, 7, -1);
        schedM5   = makeSched(3'd5, CC_NZ, 1'b0, 1'b1, 8, -1);

        reset         = 1'b1;
        mcycle_tick_i = 1'b0;
        sched_i       = '0;
        isr_sched_i   = '0;
        irq_req_i     = 1'b0;
        flags_i       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_ctrl", cw(ctrl_o), cw(expFetch));
        checkOutput("reset_step", 32'(step_o), 32'd0);
        checkOutput("reset_cb", 32'(cb_mode_o), 32'd0);
        checkOutput("reset_done", 32'(instr_done_o), 32'd0);
        checkOutput("reset_ack", 32'(irq_ack_o), 32'd0);
        checkOutput("reset_bitcmd", 32'(bit_cmd_o), 32'd0);

        applyStimulus(1'b0);
        checkOutput("boot_hold", cw(ctrl_o), cw(expFetch));

        // Three-step instruction walks 0,1,2 and ends on the third tick.
        sched_i = schedA;
        applyStimulus(1'b1);
        checkOutput("boot_load_nop", cw(ctrl_o), 32'd0);
        checkOutput("boot_load_done", 32'(instr_done_o), 32'd0);
        applyStimulus(1'b0);
        checkOutput("a_step0_ctrl", cw(ctrl_o), cw(makeCtrl(16, 1'b0)));
        checkOutput("a_step0_step", 32'(step_o), 32'd0);
        checkOutput("a_bitcmd", 32'(bit_cmd_o), 32'd1);
        applyStimulus(1'b0);
        checkOutput("a_step0_stable", cw(ctrl_o), cw(makeCtrl(16, 1'b0)));
        applyStimulus(1'b1);
        checkOutput("a_step1_ctrl", cw(ctrl_o), cw(makeCtrl(17, 1'b0)));
        checkOutput("a_step1_step", 32'(step_o), 32'd1);
        checkOutput("a_step1_done", 32'(instr_done_o), 32'd0);
        applyStimulus(1'b1);
        checkOutput("a_step2_ctrl", cw(ctrl_o), cw(makeCtrl(18, 1'b0)));
        checkOutput("a_step2_step", 32'(step_o), 32'd2);
        checkOutput("a_step2_done", 32'(instr_done_o), 32'd0);
        sched_i    = schedJr;
        flags_i.z  = 1'b1;
        applyStimulus(1'b1);
        checkOutput("a_done", 32'(instr_done_o), 32'd1);
        checkOutput("a_load_nop", cw(ctrl_o), 32'd0);

        // JR NZ with Z=1: condition fails at step 1, instruction ends early.
        applyStimulus(1'b0);
        checkOutput("jr_taken0_ctrl", cw(ctrl_o), cw(makeCtrl(32, 1'b0)));
        checkOutput("jr_bitcmd", 32'(bit_cmd_o), 32'd0);
        checkOutput("jr_done_clear", 32'(instr_done_o), 32'd0);
        applyStimulus(1'b1);
        checkOutput("jr_z1_step1", cw(ctrl_o), cw(makeCtrl(33, 1'b1)));
        applyStimulus(1'b1);
        checkOutput("jr_z1_done", 32'(instr_done_o), 32'd1);
        checkOutput("jr_z1_nop", cw(ctrl_o), 32'd0);

        // JR NZ with Z=0: condition passes, full three steps.
        applyStimulus(1'b0);
        flags_i.z = 1'b0;
        checkOutput("jr_z0_step0", cw(ctrl_o), cw(makeCtrl(32, 1'b0)));
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("jr_z0_step2", cw(ctrl_o), cw(makeCtrl(34, 1'b0)));
        checkOutput("jr_z0_step2_done", 32'(instr_done_o), 32'd0);
        sched_i = schedPre;
        applyStimulus(1'b1);
        checkOutput("jr_z0_done", 32'(instr_done_o), 32'd1);

        // CB prefix: a pending interrupt must wait until after the CB opcode.
        applyStimulus(1'b0);
        checkOutput("pre_ctrl", cw(ctrl_o), cw(makeCtrl(48, 1'b0)));
        checkOutput("pre_cbmode", 32'(cb_mode_o), 32'd1);
        irq_req_i   = 1'b1;
        sched_i     = schedCbOp;
        isr_sched_i = schedIsr;
        applyStimulus(1'b1);
        checkOutput("pre_done", 32'(instr_done_o), 32'd1);
        applyStimulus(1'b0);
        checkOutput("cbop_ctrl", cw(ctrl_o), cw(makeCtrl(64, 1'b0)));
        checkOutput("cbop_cbmode", 32'(cb_mode_o), 32'd0);
        checkOutput("cbop_no_ack", 32'(irq_ack_o), 32'd0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("cbop_done", 32'(instr_done_o), 32'd1);

        // Interrupt dispatch schedule of five steps.
        applyStimulus(1'b0);
        checkOutput("isr_ack", 32'(irq_ack_o), 32'd1);
        checkOutput("isr_step0", cw(ctrl_o), cw(makeCtrl(80, 1'b0)));
        irq_req_i = 1'b0;
        applyStimulus(1'b0);
        checkOutput("isr_ack_pulse", 32'(irq_ack_o), 32'd0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("isr_step%0d_ctrl", i), cw(ctrl_o), cw(makeCtrl(80 + i, 1'b0)));
            checkOutput($sformatf("isr_step%0d_idx", i), 32'(step_o), 32'(i));
        end
        sched_i = schedM0;
        applyStimulus(1'b1);
        checkOutput("isr_done", 32'(instr_done_o), 32'd1);

        // m_cycles=0 behaves as a single step.
        applyStimulus(1'b0);
        checkOutput("m0_ctrl", cw(ctrl_o), cw(makeCtrl(96, 1'b0)));
        sched_i = schedM7;
        applyStimulus(1'b1);
        checkOutput("m0_done", 32'(instr_done_o), 32'd1);

        // m_cycles=7 is clamped to the six-entry table.
        applyStimulus(1'b0);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("m7_step%0d_idx", i), 32'(step_o), 32'(i));
            checkOutput($sformatf("m7_step%0d_done", i), 32'(instr_done_o), 32'd0);
        end
        checkOutput("m7_step5_ctrl", cw(ctrl_o), cw(makeCtrl(117, 1'b0)));
        sched_i = schedM5;
        applyStimulus(1'b1);
        checkOutput("m7_done", 32'(instr_done_o), 32'd1);
        checkOutput("m7_nop", cw(ctrl_o), 32'd0);

        // Reset in the middle of an instruction returns to BOOT.
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("m5_step2", 32'(step_o), 32'd2);
        reset = 1'b1;
        applyStimulus(1'b0);
        reset = 1'b0;
        checkOutput("midreset_ctrl", cw(ctrl_o), cw(expFetch));
        checkOutput("midreset_step", 32'(step_o), 32'd0);
        checkOutput("midreset_bitcmd", 32'(bit_cmd_o), 32'd0);
        applyStimulus(1'b0);
        checkOutput("midreset_hold", cw(ctrl_o), cw(expFetch));
        applyStimulus(1'b1);
        checkOutput("midreset_load", cw(ctrl_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
